// File: rtl/conjugate_result_writeback_pkg.sv
// Shared types, derived-size helpers and padding mask builder for the
// conjugate result writeback stage.
package conjugate_result_writeback_pkg;

    localparam int unsigned MAX_LANES = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        DONE   = 2'd2
    } state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < {32'd0, v}) r = i + 1;
        end
        return r;
    endfunction

    function automatic int unsigned calc_total_blocks(input int unsigned n, input int unsigned u);
        return (n + u - 1) / u;
    endfunction

    function automatic int unsigned calc_valid_lanes_last(input int unsigned n, input int unsigned u);
        return n - (calc_total_blocks(n, u) - 1) * u;
    endfunction

    function automatic int unsigned calc_addr_width(input int unsigned n, input int unsigned u);
        int unsigned w;
        w = clog2(calc_total_blocks(n, u));
        return (w < 1) ? 1 : w;
    endfunction

    // Bit k set means lane k of the final word carries a real equation.
    function automatic logic [MAX_LANES-1:0] lane_mask(input int unsigned valid_lanes);
        logic [MAX_LANES-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_LANES; i++) begin
            m[i] = (i < valid_lanes);
        end
        return m;
    endfunction

    localparam int unsigned DEF_EQUATIONS    = 19;
    localparam int unsigned DEF_UNITS        = 8;
    localparam int unsigned TOTAL_BLOCKS     = calc_total_blocks(DEF_EQUATIONS, DEF_UNITS);
    localparam int unsigned VALID_LANES_LAST = calc_valid_lanes_last(DEF_EQUATIONS, DEF_UNITS);
    localparam int unsigned ADDR_WIDTH       = calc_addr_width(DEF_EQUATIONS, DEF_UNITS);

endpackage

// File: rtl/conjugate_result_writeback_ram.sv
// Simple dual-port block memory: synchronous write, registered read-first read
// with a clear input that forces the read register to zero.
module result_block_ram #(
    parameter int unsigned depth      = 3,
    parameter int unsigned width      = 512,
    parameter int unsigned addr_width = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [addr_width-1:0] waddr,
    input  logic [width-1:0]      wdata,
    input  logic                  rd_en,
    input  logic                  rd_clr,
    input  logic [addr_width-1:0] raddr,
    output logic [width-1:0]      rd_data
);

    logic [width-1:0] mem [depth];
    logic [width-1:0] rd_data_q;
    logic [width-1:0] rd_data_d;

    // Contents survive reset on purpose: stale words stay readable.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) rd_data_d = rd_clr ? '0 : mem[raddr];
    end

    always_ff @(posedge clk) begin
        if (reset) rd_data_q <= '0;
        else       rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/conjugate_result_writeback.sv
// Captures one multi-lane result word per strobe into block memory, zeroes the
// padding lanes of the final word and flags cluster completion.
module conjugate_result_writeback
    import conjugate_result_writeback_pkg::*;
#(
    parameter  int unsigned number_of_equations_per_cluster = 19,
    parameter  int unsigned element_width                   = 64,
    parameter  int unsigned no_of_units                     = 8,
    localparam int unsigned total_blocks     = calc_total_blocks(number_of_equations_per_cluster, no_of_units),
    localparam int unsigned valid_lanes_last = calc_valid_lanes_last(number_of_equations_per_cluster, no_of_units),
    localparam int unsigned addr_width       = calc_addr_width(number_of_equations_per_cluster, no_of_units),
    localparam int unsigned word_width       = element_width * no_of_units
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  result_mem_we,
    input  logic [word_width-1:0] vXc_add_8_output,
    input  logic                  rd_en,
    input  logic [addr_width-1:0] rd_addr,
    output logic [word_width-1:0] rd_data,
    output logic                  rd_valid,
    output logic [addr_width:0]   wr_ptr,
    output logic                  done,
    output logic                  overflow
);

    localparam logic [no_of_units-1:0] last_lane_mask = no_of_units'(lane_mask(valid_lanes_last));

    state_e                state_q, state_d;
    logic [addr_width:0]   wr_ptr_q, wr_ptr_d;
    logic                  done_q, done_d;
    logic                  overflow_q, overflow_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  mem_we_c;
    logic                  last_c;
    logic                  rd_clr_c;
    logic [word_width-1:0] wdata_c;

    assign last_c   = (wr_ptr_q == (addr_width + 1)'(total_blocks - 1));
    assign rd_clr_c = ({1'b0, rd_addr} >= (addr_width + 1)'(total_blocks));

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // start overrides everything, including a coincident strobe.
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = ACCEPT;
        end else begin
            case (state_q)
                ACCEPT:  if (result_mem_we && last_c) state_d = DONE;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        done_d     = done_q;
        overflow_d = overflow_q;
        mem_we_c   = 1'b0;
        rd_valid_d = rd_en;
        if (start) begin
            wr_ptr_d   = '0;
            done_d     = 1'b0;
            overflow_d = 1'b0;
        end else if (result_mem_we) begin
            if (state_q == ACCEPT) begin
                mem_we_c = 1'b1;
                wr_ptr_d = wr_ptr_q + (addr_width + 1)'(1);
                if (last_c) done_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Lanes past the last real equation are stored as zero.
    always_comb begin
        wdata_c = vXc_add_8_output;
        if (last_c) begin
            for (int unsigned k = 0; k < no_of_units; k++) begin
                if (!last_lane_mask[k]) wdata_c[k*element_width +: element_width] = '0;
            end
        end
    end

    result_block_ram #(
        .depth      (total_blocks),
        .width      (word_width),
        .addr_width (addr_width)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .we      (mem_we_c),
        .waddr   (wr_ptr_q[addr_width-1:0]),
        .wdata   (wdata_c),
        .rd_en   (rd_en),
        .rd_clr  (rd_clr_c),
        .raddr   (rd_addr),
        .rd_data (rd_data)
    );

    assign wr_ptr   = wr_ptr_q;
    assign done     = done_q;
    assign overflow = overflow_q;
    assign rd_valid = rd_valid_q;

endmodule
